// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared types and constants for the HDMI data-island packetizer.
//   pkt_t    : one queued packet, four 56-bit subpackets above the 24-bit header
//   state_t  : packetizer FSM states
//   BCH_POLY : feedback constant of the BCH(64,56)/(32,24) ECC
//   bch_step : advances an ECC register by one serial bit
package hdmi_pkg;

  localparam logic [7:0] BCH_POLY = 8'h83;
  localparam int         PKT_W    = 248;

  typedef struct packed {
    logic [3:0][55:0] sub;
    logic [23:0]      hdr;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN
  } state_t;

  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
    return (ecc >> 1) ^ ((ecc[0] ^ b) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/hdmi_packet_fifo.sv
// hdmi_packet_fifo: show-ahead FIFO holding whole packets.
//   clk_pixel, reset : clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_wdata  : write strobe and packet word
//   i_pop            : consume the head entry (ignored when empty)
//   o_rdata          : head entry, valid whenever !o_empty
//   o_full, o_empty  : occupancy flags
// A push while full is taken when a pop happens in the same cycle.
module hdmi_packet_fifo
  import hdmi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PKT_W
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wp;
  logic [AW-1:0]               r_rp;
  logic [AW:0]                 r_cnt;
  logic                        w_push;
  logic                        w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rp];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_pixel) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/hdmi_island_packetizer.sv
// hdmi_island_packetizer: queues HDMI packets and serialises them, 32 cycles
// each, into data islands granted by the video timing scheduler.
//   clk_pixel, reset           : pixel clock, asynchronous active-high reset
//   pkt_valid/pkt_ready        : packet push handshake (header + 4 subpackets)
//   pkt_header, pkt_sub        : packet content, bit 0 transmitted first
//   island_start               : one-cycle island grant
//   island_active, island_last : packet_data valid / final cycle of island
//   packet_data                : [0] header+ECC, [4:1] even, [8:5] odd sub bits
//   counter                    : bit position inside the current packet
//   packets_sent               : packets in the current or most recent island
// Optional feature: define PACKETIZER_NULL_FILL_EN to send one null packet
// when an island is granted with nothing queued.
module hdmi_island_packetizer
  import hdmi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_PACKETS = 18
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [23:0]      pkt_header,
  input  logic [3:0][55:0] pkt_sub,
  input  logic             island_start,
  output logic             island_active,
  output logic             island_last,
  output logic [8:0]       packet_data,
  output logic [4:0]       counter,
  output logic [4:0]       packets_sent
);

  state_t           r_state;
  state_t           w_state_nxt;
  pkt_t             r_pkt;
  logic [4:0]       r_cnt;
  logic [7:0]       r_hecc;
  logic [3:0][7:0]  r_secc;
  logic [4:0]       r_sent;

  logic [PKT_W-1:0] w_fifo_rdata;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_null;
  logic             w_hbit;
  logic [3:0]       w_even;
  logic [3:0]       w_odd;
  logic [5:0]       w_bidx_e;
  logic [5:0]       w_bidx_o;

  assign w_push    = pkt_valid && pkt_ready;
  assign pkt_ready = !w_full && !reset;
  assign w_pop     = w_load && !w_null;

  hdmi_packet_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .i_push    (w_push),
    .i_wdata   ({pkt_sub, pkt_header}),
    .i_pop     (w_pop),
    .o_rdata   (w_fifo_rdata),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_null      = 1'b0;
    island_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (island_start) begin
          if (!w_empty) begin
            w_load      = 1'b1;
            w_state_nxt = SEND;
          end
`ifdef PACKETIZER_NULL_FILL_EN
          else begin
            w_load      = 1'b1;
            w_null      = 1'b1;
            w_state_nxt = SEND;
          end
`endif
        end
      end
      SEND: begin
        if (r_cnt == 5'd31) begin
          if (!w_empty && (r_sent < 5'(MAX_PACKETS))) begin
            w_load = 1'b1;
          end else begin
            island_last = 1'b1;
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Raw bits at the current position; only meaningful while inside the
  // payload range (header 0..23, subpackets 0..27).
  assign w_bidx_e = {r_cnt, 1'b0};
  assign w_bidx_o = {r_cnt, 1'b1};
  assign w_hbit   = (r_cnt < 5'd24) ? r_pkt.hdr[r_cnt] : 1'b0;

  always_comb begin
    w_even = '0;
    w_odd  = '0;
    if (r_cnt < 5'd28) begin
      for (int i = 0; i < 4; i++) begin
        w_even[i] = r_pkt.sub[i][w_bidx_e];
        w_odd[i]  = r_pkt.sub[i][w_bidx_o];
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_pkt  <= '0;
      r_cnt  <= '0;
      r_hecc <= '0;
      r_secc <= '0;
      r_sent <= '0;
    end else if (w_load) begin
      r_pkt  <= w_null ? pkt_t'('0) : pkt_t'(w_fifo_rdata);
      r_cnt  <= '0;
      r_hecc <= '0;
      r_secc <= '0;
      // Loading from IDLE opens a new island: restart the count at one.
      r_sent <= (r_state == IDLE) ? 5'd1 : r_sent + 5'd1;
    end else if (r_state == SEND) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt < 5'd24) r_hecc <= bch_step(r_hecc, w_hbit);
      if (r_cnt < 5'd28) begin
        for (int i = 0; i < 4; i++)
          r_secc[i] <= bch_step(bch_step(r_secc[i], w_even[i]), w_odd[i]);
      end
    end
  end

  // ECC positions: counter 24..31 maps to header ECC bit counter[2:0],
  // counter 28..31 maps to sub ECC bit pair counter[1:0].
  always_comb begin
    packet_data = '0;
    if (r_state == SEND) begin
      packet_data[0] = (r_cnt < 5'd24) ? w_hbit : r_hecc[r_cnt[2:0]];
      for (int i = 0; i < 4; i++) begin
        if (r_cnt < 5'd28) begin
          packet_data[1+i] = w_even[i];
          packet_data[5+i] = w_odd[i];
        end else begin
          packet_data[1+i] = r_secc[i][{r_cnt[1:0], 1'b0}];
          packet_data[5+i] = r_secc[i][{r_cnt[1:0], 1'b1}];
        end
      end
    end
  end

  assign island_active = (r_state == SEND);
  assign counter       = r_cnt;
  assign packets_sent  = r_sent;

endmodule

// File: tb/tb_hdmi_island_packetizer.sv
// Scoreboard bench for hdmi_island_packetizer: every accepted packet pushes its
// 32 expected beats; a monitor pops one beat per active cycle and compares.
module tb_hdmi_island_packetizer;

  logic             clk_pixel = 1'b0;
  logic             reset;
  logic             pkt_valid = 1'b0;
  logic             pkt_ready;
  logic [23:0]      pkt_header = '0;
  logic [3:0][55:0] pkt_sub = '0;
  logic             island_start = 1'b0;
  logic             island_active;
  logic             island_last;
  logic [8:0]       packet_data;
  logic [4:0]       counter;
  logic [4:0]       packets_sent;

  int total = 0;
  int bad   = 0;
  int act_cycles = 0;
  int last_cnt   = 0;
  logic [13:0] exp_q[$];
  logic [13:0] mon_e;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_island_packetizer #(.FIFO_DEPTH(4), .MAX_PACKETS(18)) dut (
    .clk_pixel     (clk_pixel),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_header    (pkt_header),
    .pkt_sub       (pkt_sub),
    .island_start  (island_start),
    .island_active (island_active),
    .island_last   (island_last),
    .packet_data   (packet_data),
    .counter       (counter),
    .packets_sent  (packets_sent)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  // Expected beats {counter, packet_data} for one packet.
  function automatic void exp_packet(input logic [23:0] h, input logic [3:0][55:0] s);
    logic [7:0] he;
    logic [7:0] se [4];
    logic [8:0] d;
    he = '0;
    for (int b = 0; b < 24; b++) he = step(he, h[b]);
    for (int i = 0; i < 4; i++) begin
      se[i] = '0;
      for (int b = 0; b < 56; b++) se[i] = step(se[i], s[i][b]);
    end
    for (int c = 0; c < 32; c++) begin
      d = '0;
      d[0] = (c < 24) ? h[c] : he[c-24];
      for (int i = 0; i < 4; i++) begin
        if (c < 28) begin
          d[1+i] = s[i][2*c];
          d[5+i] = s[i][2*c+1];
        end else begin
          d[1+i] = se[i][2*(c-28)];
          d[5+i] = se[i][2*(c-28)+1];
        end
      end
      exp_q.push_back({5'(c), d});
    end
  endfunction

  function automatic logic [23:0] pk_h(input int k);
    return {8'hA5 ^ 8'(k), 8'(k * 7), 8'(k)};
  endfunction

  function automatic logic [3:0][55:0] pk_s(input int k);
    logic [3:0][55:0] s;
    for (int i = 0; i < 4; i++) s[i] = 56'(64'h9E3779B97F4A7C15 * 64'(k * 4 + i + 1));
    return s;
  endfunction

  // Monitor: one scoreboard beat per active cycle, quiet outputs otherwise.
  always @(negedge clk_pixel) begin
    if (island_active) begin
      act_cycles++;
      if (island_last) last_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected: got %0h with empty scoreboard", {counter, packet_data});
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat", {counter, packet_data}, mon_e);
      end
    end else if (!reset) begin
      chk("idle_out", {island_last, counter, packet_data}, 32'h0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pixel);
    #1;
  endtask

  task automatic push(input logic [23:0] h, input logic [3:0][55:0] s);
    bit done = 1'b0;
    pkt_header = h;
    pkt_sub    = s;
    pkt_valid  = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_pixel);
      if (pkt_ready) done = 1'b1;
      @(posedge clk_pixel);
      #1;
    end
    pkt_valid = 1'b0;
    if (done) exp_packet(h, s);
    else chk("push_timeout", 32'(done), 32'd1);
  endtask

  task automatic start_island();
    island_start = 1'b1;
    tick(1);
    island_start = 1'b0;
  endtask

  task automatic wait_island_done(input int bound);
    bit seen = 1'b0;
    bit ended = 1'b0;
    for (int k = 0; k < bound && !ended; k++) begin
      @(negedge clk_pixel);
      if (island_active) seen = 1'b1;
      else if (seen) ended = 1'b1;
    end
    chk("island_end", 32'(ended), 32'd1);
    tick(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hs;
    int c;
    logic lastat;

    // Reset state
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(pkt_ready), 32'd0);
    chk("rst_out", {island_active, island_last, packet_data}, 32'd0);
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("post_rst_ready", 32'(pkt_ready), 32'd1);
    chk("post_rst_sent", 32'(packets_sent), 32'd0);

    // Single packet, header 1: serial header stream is {ECC 4A, header 000001}
    push(24'h000001, '0);
    act_cycles = 0; last_cnt = 0;
    start_island();
    hs = '0; c = 0; lastat = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_pixel);
      if (island_active && c < 32) begin
        hs[c] = packet_data[0];
        if (counter == 5'd31) lastat = island_last;
        c++;
      end
    end
    tick(1);
    chk("hdr_ecc_stream", hs, 32'h4A000001);
    chk("last_at_31", 32'(lastat), 32'd1);
    chk("act_single", act_cycles, 32);
    chk("last_single", last_cnt, 1);
    chk("sent_single", 32'(packets_sent), 32'd1);

    // Island grant with nothing queued
    act_cycles = 0;
`ifdef PACKETIZER_NULL_FILL_EN
    exp_packet('0, '0);
`endif
    start_island();
    tick(40);
`ifdef PACKETIZER_NULL_FILL_EN
    chk("empty_grant_act", act_cycles, 32);
`else
    chk("empty_grant_act", act_cycles, 0);
`endif
    chk("empty_grant_sent", 32'(packets_sent), 32'd1);

    // Fill to capacity, refill after the first pop, stray grant mid-SEND
    for (int k = 1; k <= 4; k++) push(pk_h(k), pk_s(k));
    chk("full_ready", 32'(pkt_ready), 32'd0);
    act_cycles = 0; last_cnt = 0;
    start_island();
    push(pk_h(5), pk_s(5));
    chk("refill_full", 32'(pkt_ready), 32'd0);
    chk("refill_active", 32'(island_active), 32'd1);
    tick(8);
    start_island();
    wait_island_done(400);
    chk("act_five", act_cycles, 160);
    chk("last_five", last_cnt, 1);
    chk("sent_five", 32'(packets_sent), 32'd5);
    chk("ready_five", 32'(pkt_ready), 32'd1);

    // 20 packets against an 18-packet island limit
    act_cycles = 0; last_cnt = 0;
    for (int k = 10; k < 14; k++) push(pk_h(k), pk_s(k));
    start_island();
    for (int k = 14; k < 30; k++) push(pk_h(k), pk_s(k));
    wait_island_done(1000);
    chk("sent_max", 32'(packets_sent), 32'd18);
    chk("act_max", act_cycles, 576);
    chk("last_max", last_cnt, 1);
    chk("ready_max", 32'(pkt_ready), 32'd1);
    act_cycles = 0;
    start_island();
    wait_island_done(200);
    chk("act_rest", act_cycles, 64);
    chk("sent_rest", 32'(packets_sent), 32'd2);

    // Asynchronous reset in the middle of a packet
    push(pk_h(30), pk_s(30));
    push(pk_h(31), pk_s(31));
    start_island();
    c = 0;
    for (int k = 0; k < 100 && c == 0; k++) begin
      @(negedge clk_pixel);
      if (island_active && counter == 5'd13) c = 1;
    end
    chk("reach_cnt13", c, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_out", {island_active, island_last, packet_data}, 32'd0);
    chk("arst_cnt", {packets_sent, counter}, 32'd0);
    chk("arst_ready", 32'(pkt_ready), 32'd0);
    exp_q.delete();
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("arst_release_ready", 32'(pkt_ready), 32'd1);
    act_cycles = 0;
`ifdef PACKETIZER_NULL_FILL_EN
    exp_packet('0, '0);
`endif
    start_island();
    tick(40);
`ifdef PACKETIZER_NULL_FILL_EN
    chk("arst_fifo_empty", act_cycles, 32);
`else
    chk("arst_fifo_empty", act_cycles, 0);
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_island_packetizer.md
HDMI_ISLAND_PACKETIZER -- requirements
Module: hdmi_island_packetizer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued packets (power of 2, 2..16).
REQ-002 SHALL have parameter MAX_PACKETS, default 18, meaning the maximum packets per data island (1..18).
REQ-003 SHALL have port clk_pixel, input, 1 bit: the pixel clock, the single clock of the block.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pkt_valid, input, 1 bit: the producer offers a packet.
REQ-006 SHALL have port pkt_ready, output, 1 bit: the FIFO can accept a packet.
REQ-007 SHALL have port pkt_header, input, 24 bits: header bytes HB0..HB2, HB0 in bits [7:0].
REQ-008 SHALL have port pkt_sub, input, 4x56 bits: subpackets 0..3, bit 0 sent first.
REQ-009 SHALL have port island_start, input, 1 bit: single-cycle pulse from the video timing scheduler granting an island.
REQ-010 SHALL have port island_active, output, 1 bit: packet_data is valid this cycle.
REQ-011 SHALL have port island_last, output, 1 bit: high in the final cycle of the island.
REQ-012 SHALL have port packet_data, output, 9 bits: bit 0 is the header/ECC bit; bits [4:1] are even sub bits of subpackets 0..3; bits [8:5] are odd sub bits of subpackets 0..3.
REQ-013 SHALL have port counter, output, 5 bits: position within the current 32-cycle packet.
REQ-014 SHALL have port packets_sent, output, 5 bits: packets emitted in the current or most recent island.

Function
REQ-015 SHALL accept a packet into the FIFO on any clk_pixel edge where pkt_valid && pkt_ready.
REQ-016 SHALL drive pkt_ready = !full, including in a cycle where a pop occurs.
REQ-017 SHALL implement the FSM states IDLE, SEND and DRAIN.
REQ-018 SHALL, in IDLE, ignore island_start when the FIFO is empty; otherwise pop the FIFO into the shadow packet register and enter SEND with counter=0.
REQ-019 SHALL ignore island_start while in SEND or DRAIN.
REQ-020 SHALL, in SEND, hold island_active=1 and increment counter every cycle, wrapping from 31 to 0.
REQ-021 SHALL, at counter 0..23, place header bit [counter] on packet_data[0]; at 24..31, place header ECC bit [counter-24].
REQ-022 SHALL, at counter 0..27, place sub[i] bits [2*counter] and [2*counter+1] on the lanes defined in REQ-012; at 28..31, place sub ECC i bits [2*(counter-28)] and [2*(counter-28)+1].
REQ-023 SHALL compute ECC as BCH(64,56)/(32,24) with ecc_next = (ecc>>1) ^ ((ecc[0]^bit) ? 8'h83 : 0), starting from 0 for each packet; sub ECC advances 2 bits per cycle, header ECC 1 bit per cycle.
REQ-024 SHALL, at counter=31, load the next packet from the FIFO if it is non-empty and packets_sent < MAX_PACKETS; otherwise assert island_last and enter DRAIN.
REQ-025 SHALL, in DRAIN, force island_active=0 and packet_data=0 for exactly 1 cycle, then return to IDLE.
REQ-026 SHALL, in IDLE, force packet_data=0, counter=0 and island_active=0.
REQ-027 SHALL clear packets_sent at island entry, increment it at every packet load, and hold it through IDLE.
REQ-028 SHALL handle a push and a pop in the same cycle when full, leaving the count unchanged.

Reset
REQ-029 SHALL, on reset asserted at any time including mid-packet, asynchronously force IDLE, empty the FIFO, and zero the ECC, counter and packets_sent.
REQ-030 SHALL hold pkt_ready=0 while reset is high.
REQ-031 SHALL hold island_active=0, island_last=0 and packet_data=0 while reset is high.
REQ-032 SHALL discard a partially sent packet on reset, with no resume.

Configuration
REQ-033 SHALL, with PACKETIZER_NULL_FILL_EN defined, accept island_start with an empty FIFO and emit one null packet (header 0, subs 0, ECC 0) counted in packets_sent.
REQ-034 SHALL, without PACKETIZER_NULL_FILL_EN, behave as REQ-018.

Structure
REQ-035 SHALL place the packet struct (header + 4 subs), the FSM state enum and the constant BCH_POLY=8'h83 in package hdmi_pkg.
REQ-036 SHALL implement the FIFO as sub-module hdmi_packet_fifo (FIFO_DEPTH entries, 248-bit wide).

Verification
REQ-037 SHALL cover: push 1 packet with header 24'h000001 and subs 0, pulse island_start -> 32 active cycles, packet_data[0] at counter 24..31 = 0,1,0,1,0,0,1,0 (ECC 8'h4A), then island_last.
REQ-038 SHALL cover: push 20 packets with MAX_PACKETS=18 -> packets_sent=18, 576 active cycles, 2 packets remain queued, pkt_ready=1.
REQ-039 SHALL cover: fill the FIFO to 4 -> pkt_ready=0; during SEND, a simultaneous push and pop leaves the count at 4.
REQ-040 SHALL cover: reset at counter=13 -> outputs 0 immediately (asynchronous), FSM in IDLE, FIFO empty.
REQ-041 SHALL cover: island_start with an empty FIFO -> no activity without the macro; one all-zero packet with PACKETIZER_NULL_FILL_EN.
REQ-042 SHALL cover: island_start pulsed during SEND -> ignored, with packet count and timing unchanged.
